// File: rtl/rom_sdram_writer.sv
// rom_sdram_writer: FIFO-buffered bridge from ROM loader write strobes to one-at-a-time SDRAM req/ack writes.
// Defining ROM_WR_CHECKSUM_EN adds a running 16-bit checksum of accepted words.
module rom_sdram_writer #(
  parameter int DEPTH_LOG2  = 3,
  parameter int WAIT_MARGIN = 2
) (
  input  logic        clk_sys,
  input  logic        nreset,
  input  logic        wr_68k,
  input  logic        wr_tiles,
  input  logic        wr_sprites,
  input  logic        wr_theme,
  input  logic [25:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        sdram_req,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_din,
  input  logic        sdram_ack,
  output logic        ioctl_wait,
  output logic        drained,
  output logic        overflow,
  output logic [15:0] checksum
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] L_WAIT = (DEPTH_LOG2+1)'(DEPTH - WAIT_MARGIN);
  typedef enum logic {S_IDLE, S_REQ} state_t;
  state_t r_state, w_state_nxt;
  logic [40:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0] r_count;
  logic r_any_wr_q, w_any_wr, w_push, w_accept, w_issue, w_pop, w_unused;
  assign w_any_wr = wr_68k | wr_tiles | wr_sprites | wr_theme;
  assign w_push = w_any_wr & ~r_any_wr_q;
  assign w_accept = w_push & (r_count != L_FULL);
  assign w_issue = (r_state == S_IDLE) & (r_count != '0);
  assign w_pop = (r_state == S_REQ) & sdram_ack;
  assign w_unused = wr_addr[25];
  assign drained = (r_state == S_IDLE) & (r_count == '0) & ~sdram_req;
  always_comb w_state_nxt = w_issue ? S_REQ : w_pop ? S_IDLE : r_state;
  always_ff @(posedge clk_sys)
    r_state <= !nreset ? S_IDLE : w_state_nxt;
  always_ff @(posedge clk_sys)
    if (w_accept) r_mem[r_wptr] <= {wr_addr[24:0], wr_data};
  always_ff @(posedge clk_sys) begin
    if (!nreset) begin
      r_any_wr_q <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      ioctl_wait <= 1'b0;
      overflow   <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      sdram_din  <= '0;
    end else begin
      r_any_wr_q <= w_any_wr;
      r_count    <= r_count + (DEPTH_LOG2+1)'(w_accept) - (DEPTH_LOG2+1)'(w_pop);
      ioctl_wait <= r_count >= L_WAIT;
      overflow   <= overflow | (w_push & ~w_accept);
      if (w_accept) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop) r_rptr <= r_rptr + DEPTH_LOG2'(1);
      if (w_issue) begin
        sdram_req <= 1'b1;
        {sdram_addr, sdram_din} <= r_mem[r_rptr];
      end else if (w_pop) begin
        sdram_req <= 1'b0;
      end
    end
  end
`ifdef ROM_WR_CHECKSUM_EN
  always_ff @(posedge clk_sys)
    if (!nreset) checksum <= '0;
    else if (w_accept) checksum <= checksum + wr_data;
`else
  assign checksum = 16'h0000;
`endif
endmodule
